// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: funct3 encodings and FSM state type shared by the data-memory responder
package dmem_responder_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/dmem_responder_load_align.sv
// dmem_responder_load_align: lane selection/extension for loads, byte-enable and merge for stores
module dmem_responder_load_align
  import dmem_responder_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic        we,
  output logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic        err
);
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] wsh;
  logic        mis, ill;
  assign b   = word[{off, 3'b000} +: 8];
  assign h   = word[{off[1], 4'b0000} +: 16];
  assign mis = (funct3[1:0] == 2'b01 && off[0]) || (funct3[1:0] == 2'b10 && off != 2'b00);
  assign ill = we ? (funct3[2] || funct3[1:0] == 2'b11) : (funct3[1:0] == 2'b11 || funct3[2:1] == 2'b11);
  assign err = mis || ill;
  assign wsh = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} : funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
  // extend the selected lane for loads and build the merged word for stores
  always_comb begin
    rdata = err ? 32'h0 :
            funct3 == F3_B  ? {{24{b[7]}}, b} :
            funct3 == F3_H  ? {{16{h[15]}}, h} :
            funct3 == F3_BU ? {24'h0, b} :
            funct3 == F3_HU ? {16'h0, h} : word;
    be = err ? 4'b0000 :
         funct3[1:0] == 2'b00 ? 4'b0001 << off :
         funct3[1:0] == 2'b01 ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wword = word;
    for (int i = 0; i < 4; i++) wword[8*i +: 8] = be[i] ? wsh[8*i +: 8] : word[8*i +: 8];
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: word RAM behind a valid/ready port with wait states, sub-word access and error responses
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = $clog2(LATENCY + 1) + 1;
  state_t          state, nxt;
  logic [CW-1:0]   cnt;
  logic            c_we;
  logic [31:0]     c_off, c_wdata;
  logic [2:0]      c_f3;
  logic            hs, commit, oor, bad;
  logic            s_we;
  logic [31:0]     s_off, s_wdata, rd_word, al_rdata, al_wword;
  logic [2:0]      s_f3;
  logic [3:0]      al_be;
  logic            al_err;
  logic [AW-1:0]   idx;
  logic [31:0]     mem [DEPTH_WORDS];
  assign req_ready = rst && state == IDLE;
  assign rsp_valid = state == RESP;
  assign hs        = req_valid && req_ready;
  // with zero latency the commit happens on the accepting edge, so use the live request then
  assign s_we    = state == IDLE ? req_we : c_we;
  assign s_off   = state == IDLE ? req_addr - BASE_ADDR : c_off;
  assign s_wdata = state == IDLE ? req_wdata : c_wdata;
  assign s_f3    = state == IDLE ? req_funct3 : c_f3;
  assign oor     = s_off >= 32'(DEPTH_WORDS * 4);
  assign idx     = s_off[AW+1:2];
  assign rd_word = oor ? 32'h0 : mem[idx];
  assign bad     = al_err || oor;
  assign commit  = nxt == RESP && state != RESP;
  dmem_responder_load_align u_align (
    .word   (rd_word),
    .wdata  (s_wdata),
    .off    (s_off[1:0]),
    .funct3 (s_f3),
    .we     (s_we),
    .rdata  (al_rdata),
    .be     (al_be),
    .wword  (al_wword),
    .err    (al_err)
  );
  // next-state selection
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = hs ? (LATENCY > 0 ? WAIT : RESP) : IDLE;
      WAIT:    nxt = int'(cnt) == LATENCY - 1 ? RESP : WAIT;
      RESP:    nxt = rsp_ready ? IDLE : RESP;
      default: nxt = IDLE;
    endcase
  end
  // state, request capture, wait counter and registered response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      c_we      <= 1'b0;
      c_off     <= 32'h0;
      c_wdata   <= 32'h0;
      c_f3      <= 3'b000;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      state <= nxt;
      if (hs) begin
        c_we    <= req_we;
        c_off   <= req_addr - BASE_ADDR;
        c_wdata <= req_wdata;
        c_f3    <= req_funct3;
        cnt     <= '0;
      end else if (state == WAIT) cnt <= cnt + 1'b1;
      if (commit) begin
        rsp_rdata <= s_we || bad ? 32'h0 : al_rdata;
        rsp_err   <= bad;
      end
    end
  end
  // RAM write on the commit edge; contents are not reset
  always_ff @(posedge clk) begin
    if (commit && s_we && !bad && al_be != 4'b0000) mem[idx] <= al_wword;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of a LATENCY=2 and a LATENCY=0 responder
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [2:0]  f3 = 3'b000;
  logic        rsp_ready = 1'b1;
  logic [1:0]  v = 2'b00, rdy, rv, er;
  logic [31:0] rd [2];
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h0)) u_l2 (
    .clk(clk), .rst(rst_n), .req_valid(v[0]), .req_ready(rdy[0]), .req_we(we),
    .req_addr(addr), .req_wdata(wdata), .req_funct3(f3), .rsp_valid(rv[0]),
    .rsp_ready(rsp_ready), .rsp_rdata(rd[0]), .rsp_err(er[0])
  );
  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0), .BASE_ADDR(32'h0)) u_l0 (
    .clk(clk), .rst(rst_n), .req_valid(v[1]), .req_ready(rdy[1]), .req_we(we),
    .req_addr(addr), .req_wdata(wdata), .req_funct3(f3), .rsp_valid(rv[1]),
    .rsp_ready(rsp_ready), .rsp_rdata(rd[1]), .rsp_err(er[1])
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic issue(input int s, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    int n = 0;
    while (!rdy[s] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_ready_before_issue", {31'h0, rdy[s]}, 32'h1);
    we = w; addr = a; wdata = d; f3 = f; v[s] = 1'b1;
    @(posedge clk); #1;
    v[s] = 1'b0;
  endtask
  task automatic wait_rsp(input int s, output int n);
    n = 0;
    while (!rv[s] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask
  task automatic xact(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] f, input logic [31:0] exp_rd, input logic exp_err, input string tag);
    int n;
    issue(s, w, a, d, f);
    wait_rsp(s, n);
    chk({tag, "/latency"}, n, s == 0 ? 32'd2 : 32'd0);
    chk({tag, "/rdata"}, rd[s], exp_rd);
    chk({tag, "/err"}, {31'h0, er[s]}, {31'h0, exp_err});
    @(posedge clk); #1;
    chk({tag, "/valid_drop"}, {31'h0, rv[s]}, 32'h0);
  endtask
  initial begin
    logic [31:0] hold_rd;
    int n;
    #12;
    chk("reset/req_ready", {30'h0, rdy}, 32'h0);
    chk("reset/rsp_valid", {30'h0, rv}, 32'h0);
    chk("reset/rdata", rd[0], 32'h0);
    chk("reset/err", {30'h0, er}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset/req_ready", {30'h0, rdy}, 32'h3);
    for (int s = 0; s < 2; s++) begin
      xact(s, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0, "sw10");
      xact(s, 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, "lw10");
      xact(s, 1'b1, 32'h11, 32'h80, 3'b000, 32'h0, 1'b0, "sb11");
      xact(s, 1'b0, 32'h11, 32'h0, 3'b000, 32'hFFFFFF80, 1'b0, "lb11");
      xact(s, 1'b0, 32'h11, 32'h0, 3'b100, 32'h00000080, 1'b0, "lbu11");
      xact(s, 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD80EF, 1'b0, "lw10_after_sb");
      xact(s, 1'b1, 32'h12, 32'h8001, 3'b001, 32'h0, 1'b0, "sh12");
      xact(s, 1'b0, 32'h12, 32'h0, 3'b001, 32'hFFFF8001, 1'b0, "lh12");
      xact(s, 1'b0, 32'h12, 32'h0, 3'b101, 32'h00008001, 1'b0, "lhu12");
      xact(s, 1'b0, 32'h10, 32'h0, 3'b010, 32'h800180EF, 1'b0, "lw10_after_sh");
    end
    xact(0, 1'b0, 32'h13, 32'h0, 3'b010, 32'h0, 1'b1, "lw13_misaligned");
    xact(0, 1'b0, 32'h11, 32'h0, 3'b001, 32'h0, 1'b1, "lh11_misaligned");
    xact(0, 1'b1, 32'h0, 32'h11223344, 3'b010, 32'h0, 1'b0, "sw0");
    xact(0, 1'b1, 32'h1000, 32'hCAFEF00D, 3'b010, 32'h0, 1'b1, "sw1000_oor");
    xact(0, 1'b0, 32'h0, 32'h0, 3'b010, 32'h11223344, 1'b0, "lw0_unchanged");
    xact(0, 1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1, "ld_f3_011");
    xact(0, 1'b1, 32'h10, 32'h55555555, 3'b100, 32'h0, 1'b1, "st_f3_100");
    xact(0, 1'b0, 32'h10, 32'h0, 3'b010, 32'h800180EF, 1'b0, "lw10_after_bad_store");
    rsp_ready = 1'b0;
    issue(0, 1'b0, 32'h10, 32'h0, 3'b010);
    wait_rsp(0, n);
    chk("bp/latency", n, 32'd2);
    chk("bp/rdata_first", rd[0], 32'h800180EF);
    hold_rd = rd[0];
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        we = 1'b1; addr = 32'h10; wdata = 32'hFFFFFFFF; f3 = 3'b010; v[0] = 1'b1;
      end
      if (i == 2) v[0] = 1'b0;
      @(posedge clk); #1;
      chk("bp/rsp_valid", {31'h0, rv[0]}, 32'h1);
      chk("bp/rdata", rd[0], hold_rd);
      chk("bp/err", {31'h0, er[0]}, 32'h0);
      chk("bp/req_ready", {31'h0, rdy[0]}, 32'h0);
    end
    v[0] = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp/valid_drop", {31'h0, rv[0]}, 32'h0);
    xact(0, 1'b0, 32'h10, 32'h0, 3'b010, 32'h800180EF, 1'b0, "lw10_after_bp");
    xact(0, 1'b1, 32'h20, 32'h5555, 3'b010, 32'h0, 1'b0, "sw20_prior");
    issue(0, 1'b1, 32'h20, 32'h1234, 3'b010);
    rst_n = 1'b0;
    #1;
    chk("rst_wait/rsp_valid", {31'h0, rv[0]}, 32'h0);
    chk("rst_wait/req_ready", {31'h0, rdy[0]}, 32'h0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xact(0, 1'b0, 32'h20, 32'h0, 3'b010, 32'h5555, 1'b0, "lw20_after_abandon");
    rsp_ready = 1'b0;
    issue(0, 1'b0, 32'h20, 32'h0, 3'b010);
    wait_rsp(0, n);
    chk("rst_resp/valid_before", {31'h0, rv[0]}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_resp/valid_async", {31'h0, rv[0]}, 32'h0);
    chk("rst_resp/rdata", rd[0], 32'h0);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    xact(1, 1'b0, 32'h10, 32'h0, 3'b010, 32'h800180EF, 1'b0, "l0_lw10_final");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the core's load/store port: a word-organised data RAM behind a valid/ready request/response handshake.
- Adds a configurable wait-state latency, byte/half/word access per RV32I funct3, and an error response.
- Sits between the core's memory stage (initiator) and on-chip data storage, and lets the pipelined core be exercised against a non-zero-latency memory.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the RAM.
- LATENCY, 2, wait-state cycles between request acceptance and the response (0 allowed).
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified.
- req_funct3  input  3  RV32I load/store funct3.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  initiator accepts the response.
- rsp_rdata  output  32  load result, extended; 0 for stores and errors.
- rsp_err  output  1  misaligned, out-of-range or illegal funct3.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE; wait counter = 0; captured request registers = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - req_ready = 0 while rst is low.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready: capture we, addr, wdata, funct3; clear the counter.
  - Go to WAIT if LATENCY > 0, else to RESP.
- WAIT:
  - req_ready = 0; the counter increments each cycle.
  - When counter == LATENCY-1, go to RESP.
- Commit on the edge entering RESP:
  - Stores write RAM (if no error).
  - Loads register rsp_rdata/rsp_err.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable until rsp_ready.
  - On rsp_ready: go to IDLE; rsp_valid drops on the next cycle.
- Latency:
  - For a handshake in cycle T, rsp_valid is first high in cycle T+1+LATENCY.
  - Minimum spacing between accepted requests is LATENCY+2 cycles (one outstanding transaction).
- Address:
  - off = req_addr - BASE_ADDR (32-bit, wrapping).
  - Word index = off[31:2].
  - Out of range if off >= DEPTH_WORDS*4 (includes req_addr < BASE_ADDR via wrap).
- Loads:
  - 000 LB: byte lane off[1:0], sign-extended.
  - 001 LH: half lane off[1], sign-extended.
  - 010 LW: full word.
  - 100 LBU / 101 LHU: zero-extended.
- Stores:
  - 000 SB: wdata[7:0] into byte lane off[1:0].
  - 001 SH: wdata[15:0] into half lane off[1].
  - 010 SW: full word. Other lanes are untouched.
- Errors (rsp_err = 1, no RAM write, rsp_rdata = 0):
  - half with off[0] = 1;
  - word with off[1:0] != 0;
  - funct3 not listed above (loads: 011, 110, 111; stores: anything other than 000/001/010);
  - out of range.
- Stores return rsp_rdata = 0.
- Request inputs are ignored whenever req_ready = 0. The initiator may change or drop them freely.
- Reset mid-transaction:
  - In WAIT: the transaction is abandoned and no write occurs.
  - In RESP: a write already committed is kept; rsp_valid drops asynchronously.
- rsp_ready high outside RESP has no effect.

Decomposition:
- Shared package:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - state enum typedef {IDLE, WAIT, RESP}.
- Sub-module load_align (combinational):
  - Inputs: word, off[1:0], funct3.
  - Outputs: extended data, store byte-enable mask, merged store word, misaligned/illegal flag.
  - Reused by later cache work.

Test Plan:
1. LATENCY=2: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 with rsp_ready tied 1 -> each rsp_valid first high exactly 3 cycles after acceptance; load returns 0xDEADBEEF, rsp_err = 0.
2. After test 1: SB 0x11 data 0x80; LB 0x11 -> 0xFFFFFF80; LBU 0x11 -> 0x00000080; LW 0x10 -> 0xDEAD80EF.
3. SH 0x12 data 0x8001; LH 0x12 -> 0xFFFF8001; LHU 0x12 -> 0x00008001.
4. Error cases:
   - LW 0x13 -> rsp_err = 1, rsp_rdata = 0.
   - SW 0x1000 with DEPTH_WORDS=1024 -> rsp_err = 1; word 0 is unchanged on readback.
   - funct3 011 -> rsp_err = 1.
5. Backpressure: hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err are stable; req_ready = 0 throughout; a req_valid pulse during this window is not accepted.
6. LATENCY=0 rerun of tests 1-3 -> response one cycle after acceptance. Then a reset pulse during WAIT of an SW 0x20 data 0x1234 (LATENCY=2) -> rsp_valid = 0 at once; after reset, LW 0x20 returns the prior value.
